// File: rtl/sensor_cmd_pkg.sv
// Shared types and constants for the sensor command router.
package sensor_cmd_pkg;
    typedef enum logic [2:0] {IDLE, START, WAIT, SEND, ERR} state_e;

    localparam logic [7:0] CMD_ABORT   = 8'h53; // "S"
    localparam logic [7:0] CMD_CH_BASE = 8'h30; // "0"
    localparam logic [7:0] ERR_BAD_CMD = 8'hFF;
    localparam logic [7:0] ERR_TIMEOUT = 8'hFE;
endpackage

// File: rtl/sensor_cmd_router_if.sv
// UART-side byte streams: rx strobe in, tx valid/ready out.
interface sensor_cmd_router_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
    modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/sensor_tx_serializer.sv
// Frame serializer: header, payload LSB-first, optional checksum, or a lone error byte.
// SENSOR_CMD_ROUTER_CHECKSUM_EN appends a modulo-256 sum byte to each frame.
module sensor_tx_serializer #(
    parameter int CH_BYTES = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_frame,
    input  logic                  load_err,
    input  logic                  abort,
    input  logic [7:0]            cmd,
    input  logic [7:0]            err_code,
    input  logic [8*CH_BYTES-1:0] payload,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  done
);
    localparam int DATA_W = 8*CH_BYTES;
`ifdef SENSOR_CMD_ROUTER_CHECKSUM_EN
    localparam logic [3:0] TAIL_BYTES = 4'(CH_BYTES + 1);
    logic [7:0] sum_q, sum_d;
`else
    localparam logic [3:0] TAIL_BYTES = 4'(CH_BYTES);
`endif

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [3:0]        left_q, left_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            left_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef SENSOR_CMD_ROUTER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            shreg_q <= shreg_d;
            left_q  <= left_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef SENSOR_CMD_ROUTER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // left_q counts bytes still to follow the one currently on tx_data
    always_comb begin
        shreg_d = shreg_q;
        left_d  = left_q;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef SENSOR_CMD_ROUTER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (abort) begin
            valid_d = 1'b0;
            left_d  = '0;
        end else if (load_frame) begin
            valid_d = 1'b1;
            data_d  = cmd;
            shreg_d = payload;
            left_d  = TAIL_BYTES;
`ifdef SENSOR_CMD_ROUTER_CHECKSUM_EN
            sum_d   = cmd;
`endif
        end else if (load_err) begin
            valid_d = 1'b1;
            data_d  = err_code;
            left_d  = '0;
        end else if (valid_q && tx_ready) begin
            if (left_q == '0) begin
                valid_d = 1'b0;
            end else begin
                left_d = left_q - 1'b1;
`ifdef SENSOR_CMD_ROUTER_CHECKSUM_EN
                if (left_q == 4'd1) begin
                    data_d = sum_q;
                end else begin
                    data_d  = shreg_q[7:0];
                    shreg_d = shreg_q >> 8;
                    sum_d   = sum_q + shreg_q[7:0];
                end
`else
                data_d  = shreg_q[7:0];
                shreg_d = shreg_q >> 8;
`endif
            end
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign done     = valid_q && tx_ready && (left_q == '0);
endmodule

// File: rtl/sensor_cmd_router.sv
// UART command router: "0"+i starts channel i, its payload is framed back; "S" aborts.
// SENSOR_CMD_ROUTER_CHECKSUM_EN (in the serializer) adds a checksum byte per frame.
module sensor_cmd_router
    import sensor_cmd_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int CH_BYTES       = 5,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    sensor_cmd_router_if.slave           bus,
    output logic [NUM_CH-1:0]            ch_start,
    input  logic [NUM_CH*8*CH_BYTES-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_valid,
    output logic                         busy,
    output logic                         drop
);
    localparam int DATA_W = 8*CH_BYTES;
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    CH_LAST  = 8'(CMD_CH_BASE + NUM_CH - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     ch_idx_q, ch_idx_d;
    logic [7:0]        cmd_q, cmd_d, err_code;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic              rx_is_abort, rx_abort, ch_hit, ch_hit_valid, expire;
    logic              load_frame, load_err, ser_done;
    logic [DATA_W-1:0] ch_sel;

    assign rx_is_abort  = bus.rx_valid && (bus.rx_data == CMD_ABORT);
    assign rx_abort     = (state_q != IDLE) && rx_is_abort;
    assign ch_hit       = (bus.rx_data >= CMD_CH_BASE) && (bus.rx_data <= CH_LAST);
    assign ch_hit_valid = ch_valid[ch_idx_q];
    // Fires on the TIMEOUT_CYCLES-th WAIT cycle, as the counter steps onto the limit
    assign expire       = (cnt_q >= CNT_LAST);
    assign ch_sel       = ch_data[ch_idx_q*DATA_W +: DATA_W];
    assign drop         = drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_idx_q <= '0;
            cmd_q    <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: if (bus.rx_valid) begin
                if (ch_hit) begin
                    state_d  = START;
                    ch_idx_d = IW'(bus.rx_data - CMD_CH_BASE);
                    cmd_d    = bus.rx_data;
                end else if (!rx_is_abort) begin
                    state_d = ERR;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = rx_abort ? IDLE : WAIT;
            end
            WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (rx_abort)          state_d = IDLE;
                else if (ch_hit_valid) state_d = SEND;
                else if (expire)       state_d = ERR;
            end
            SEND, ERR: if (rx_abort || ser_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_start   = '0;
        load_frame = 1'b0;
        load_err   = 1'b0;
        err_code   = ERR_TIMEOUT;
        busy       = (state_q != IDLE);
        drop_d     = busy && bus.rx_valid && !rx_is_abort;
        case (state_q)
            IDLE: begin
                load_err = bus.rx_valid && !ch_hit && !rx_is_abort;
                err_code = ERR_BAD_CMD;
            end
            START: ch_start[ch_idx_q] = !rx_is_abort;
            WAIT: begin
                load_frame = ch_hit_valid && !rx_is_abort;
                load_err   = expire && !ch_hit_valid && !rx_is_abort;
            end
            default: ;
        endcase
    end

    sensor_tx_serializer #(.CH_BYTES(CH_BYTES)) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_frame (load_frame),
        .load_err   (load_err),
        .abort      (rx_abort),
        .cmd        (cmd_q),
        .err_code   (err_code),
        .payload    (ch_sel),
        .tx_ready   (bus.tx_ready),
        .tx_data    (bus.tx_data),
        .tx_valid   (bus.tx_valid),
        .done       (ser_done)
    );
endmodule

// File: tb/tb_sensor_cmd_router.sv
// Randomized bench for sensor_cmd_router with a frame-level reference model.
module tb_sensor_cmd_router;
    localparam int NUM_CH   = 2;
    localparam int CH_BYTES = 5;
    localparam int DATA_W   = 8*CH_BYTES;
    localparam int TO       = 100;
`ifdef SENSOR_CMD_ROUTER_CHECKSUM_EN
    localparam int FRAME_LEN = CH_BYTES + 2;
`else
    localparam int FRAME_LEN = CH_BYTES + 1;
`endif

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    logic [NUM_CH-1:0]        ch_start, ch_valid;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic busy, drop;

    sensor_cmd_router_if bus();

    sensor_cmd_router #(.NUM_CH(NUM_CH), .CH_BYTES(CH_BYTES), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ch_start(ch_start),
        .ch_data(ch_data), .ch_valid(ch_valid), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit rdy_rand = 1'b0;
    bit rdy_hold = 1'b0;

    logic [7:0] got_q[$];
    int start_cnt = 0, drop_cnt = 0, vld_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: accepted bytes and pulse counts, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
        if (bus.tx_valid) vld_cyc++;
        if (ch_start != '0) start_cnt++;
        if (drop) drop_cnt++;
    end

    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.tx_ready = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic model_frame(input logic [7:0] cmd, input logic [DATA_W-1:0] p, output bq_t f);
        f = {};
        f.push_back(cmd);
        for (int k = 0; k < CH_BYTES; k++) f.push_back(p[8*k +: 8]);
`ifdef SENSOR_CMD_ROUTER_CHECKSUM_EN
        begin
            int s;
            s = 0;
            foreach (f[k]) s += int'(f[k]);
            f.push_back(8'(s));
        end
`endif
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        cyc();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_ch(input int ch, input logic [DATA_W-1:0] p);
        ch_data[ch*DATA_W +: DATA_W] = p;
        ch_valid[ch] = 1'b1;
        cyc();
        ch_valid = '0;
    endtask

    task automatic wait_start(input logic [NUM_CH-1:0] exp);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (ch_start != '0) begin
                chk("start_vec", 64'(ch_start), 64'(exp));
                return;
            end
        end
        chk("start_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (!busy) return;
        end
        chk("idle_timeout", 64'(1), 64'(0));
    endtask

    task automatic check_frame(input string tag, input int base, input bq_t exp);
        chk({tag, "_len"}, 64'(got_q.size() - base), 64'(exp.size()));
        for (int k = 0; k < exp.size() && base + k < got_q.size(); k++)
            chk(tag, 64'(got_q[base + k]), 64'(exp[k]));
    endtask

    task automatic run_txn(input int ch, input logic [DATA_W-1:0] p, input int dly,
                           input bit noise, input bit dinj);
        int base, s0, d0;
        bq_t exp;
        logic [7:0] cmd;
        cmd  = 8'(8'h30 + ch);
        base = got_q.size();
        s0   = start_cnt;
        d0   = drop_cnt;
        model_frame(cmd, p, exp);
        send_rx(cmd);
        wait_start(NUM_CH'(1 << ch));
        cyc();
        if (dinj) send_rx(8'h44);
        if (noise) pulse_ch((ch + 1) % NUM_CH, ~p);
        repeat (dly) cyc();
        pulse_ch(ch, p);
        chk("lat_valid", 64'(bus.tx_valid), 64'(1));
        chk("lat_hdr", 64'(bus.tx_data), 64'(cmd));
        wait_idle();
        check_frame("frame", base, exp);
        chk("start_once", 64'(start_cnt - s0), 64'(1));
        chk("drop_cnt", 64'(drop_cnt - d0), 64'(dinj));
    endtask

    initial begin
        int base, s0, d0, v0, n, idx, ch, dly;
        bit noise, dinj;
        logic [63:0] r;
        logic [DATA_W-1:0] p;
        bq_t exp;

        rst = 1'b1;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;
        ch_valid = '0;
        ch_data = '0;
        repeat (2) cyc();
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'(0));
        chk("rst_tx_data", 64'(bus.tx_data), 64'(0));
        chk("rst_ch_start", 64'(ch_start), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_drop", 64'(drop), 64'(0));
        rst = 1'b0;
        cyc();

        // Directed frame with back-to-back handshakes
        v0 = vld_cyc;
        run_txn(1, 40'h0504030201, 3, 1'b0, 1'b0);
        chk("b2b_cycles", 64'(vld_cyc - v0), 64'(FRAME_LEN));

        // Bad command -> single 0xFF, no channel start
        base = got_q.size(); s0 = start_cnt;
        send_rx("Q");
        chk("err_busy", 64'(busy), 64'(1));
        wait_idle();
        exp = {8'hFF};
        check_frame("bad_cmd", base, exp);
        chk("bad_no_start", 64'(start_cnt - s0), 64'(0));

        // "S" while idle is ignored
        base = got_q.size();
        send_rx("S");
        chk("idle_s_busy", 64'(busy), 64'(0));
        repeat (3) cyc();
        chk("idle_s_quiet", 64'(got_q.size() - base), 64'(0));

        // Timeout: exactly TO WAIT cycles before 0xFE appears
        base = got_q.size();
        send_rx("0");
        wait_start(2'b01);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (bus.tx_valid) break;
            if (busy) n++;
        end
        chk("to_wait_cycles", 64'(n), 64'(TO));
        wait_idle();
        exp = {8'hFE};
        check_frame("timeout", base, exp);

        // ch_valid on the expiry cycle wins over the timeout
        base = got_q.size();
        p = 40'hA1B2C3D4E5;
        send_rx("1");
        wait_start(2'b10);
        cyc();
        repeat (TO - 1) cyc();
        pulse_ch(1, p);
        wait_idle();
        model_frame("1", p, exp);
        check_frame("tie", base, exp);

        // Stall mid-frame, plus a discarded byte while busy
        rdy_rand = 1'b0;
        base = got_q.size(); d0 = drop_cnt;
        r = {$urandom, $urandom}; p = r[DATA_W-1:0];
        model_frame("1", p, exp);
        send_rx("1");
        wait_start(2'b10);
        cyc();
        send_rx("D");
        pulse_ch(1, p);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (got_q.size() - base >= 2) break;
        end
        rdy_hold = 1'b1;
        cyc();
        @(negedge clk); #1;
        idx = got_q.size() - base;
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(bus.tx_valid), 64'(1));
            chk("stall_data", 64'(bus.tx_data), 64'(exp[idx]));
            @(negedge clk); #1;
        end
        chk("stall_no_accept", 64'(got_q.size() - base), 64'(idx));
        rdy_hold = 1'b0;
        wait_idle();
        check_frame("stall", base, exp);
        chk("stall_drop", 64'(drop_cnt - d0), 64'(1));

        // Abort after the second payload byte
        base = got_q.size(); d0 = drop_cnt;
        r = {$urandom, $urandom}; p = r[DATA_W-1:0];
        model_frame("0", p, exp);
        send_rx("0");
        wait_start(2'b01);
        cyc();
        pulse_ch(0, p);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (got_q.size() - base >= 3) break;
        end
        send_rx("S");
        chk("abort_valid", 64'(bus.tx_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        repeat (10) cyc();
        chk("abort_len", 64'(got_q.size() - base), 64'(3));
        for (int k = 0; k < 3 && base + k < got_q.size(); k++)
            chk("abort_bytes", 64'(got_q[base + k]), 64'(exp[k]));
        chk("abort_no_drop", 64'(drop_cnt - d0), 64'(0));
        run_txn(0, 40'h1122334455, 2, 1'b0, 1'b0);

        // Reset during SEND drops the rest of the frame
        base = got_q.size();
        rdy_hold = 1'b1;
        send_rx("1");
        wait_start(2'b10);
        cyc();
        pulse_ch(1, 40'hDEADBEEF01);
        cyc();
        chk("rst_pre_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(bus.tx_valid), 64'(0));
        chk("rst_mid_data", 64'(bus.tx_data), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        cyc();
        rst = 1'b0;
        rdy_hold = 1'b0;
        repeat (20) cyc();
        chk("rst_no_tx", 64'(got_q.size() - base), 64'(0));

`ifdef SENSOR_CMD_ROUTER_CHECKSUM_EN
        base = got_q.size();
        run_txn(0, 40'h0000000010, 1, 1'b0, 1'b0);
        if (got_q.size() > base + CH_BYTES + 1)
            chk("cksum_byte", 64'(got_q[base + CH_BYTES + 1]), 64'(8'h40));
        else
            chk("cksum_len", 64'(got_q.size() - base), 64'(FRAME_LEN));
`endif

        // Randomized traffic with random back-pressure
        rdy_rand = 1'b1;
        for (int t = 0; t < 24; t++) begin
            ch    = int'($urandom_range(0, NUM_CH - 1));
            r     = {$urandom, $urandom};
            p     = r[DATA_W-1:0];
            dly   = int'($urandom_range(0, 15));
            noise = 1'($urandom_range(0, 1));
            dinj  = 1'($urandom_range(0, 1));
            run_txn(ch, p, dly, noise, dinj);
        end
        rdy_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sensor_cmd_router.md
SENSOR_CMD_ROUTER -- requirements
Module: sensor_cmd_router

Interface
REQ-001 Parameter NUM_CH, default 2, number of sensor channels (1..8).
REQ-002 Parameter CH_BYTES, default 5, payload bytes per channel (1..8); DATA_W = 8*CH_BYTES.
REQ-003 Parameter TIMEOUT_CYCLES, default 50_000_000, clk cycles allowed between start and ch_valid.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  8  received UART byte.
REQ-007 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-008 tx_data  output  8  byte to UART transmitter.
REQ-009 tx_valid  output  1  tx_data valid; held with tx_data until tx_ready.
REQ-010 tx_ready  input  1  transmitter accepts byte when tx_valid & tx_ready.
REQ-011 ch_start  output  NUM_CH  one-cycle measurement start pulse per channel.
REQ-012 ch_data  input  NUM_CH*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
REQ-013 ch_valid  input  NUM_CH  channel i payload valid strobe.
REQ-014 busy  output  1  high whenever FSM is not IDLE.
REQ-015 drop  output  1  one-cycle pulse when a non-abort rx byte is discarded while busy.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT, SEND, ERR.
REQ-017 In IDLE, rx_valid with rx_data = "0"+i, i < NUM_CH, SHALL latch i and the command byte, and enter START.
REQ-018 In IDLE, rx_valid with "S" SHALL be ignored; any other byte SHALL load error code 0xFF and enter ERR.
REQ-019 START SHALL assert ch_start[i] for exactly one cycle, clear the timeout counter, then enter WAIT.
REQ-020 In WAIT, ch_valid[i] SHALL capture ch_data slice i into a DATA_W shift buffer and enter SEND; ch_valid of other channels SHALL be ignored.
REQ-021 In WAIT, counter reaching TIMEOUT_CYCLES without ch_valid[i] SHALL load error code 0xFE and enter ERR.
REQ-022 Capture latency: payload registered on the cycle after ch_valid[i]; first tx_valid SHALL rise that same cycle.
REQ-023 SEND SHALL emit the command byte as header, then CH_BYTES payload bytes LSB-first, then return to IDLE.
REQ-024 tx_data SHALL remain stable while tx_valid & !tx_ready; advance only on a handshake; back-to-back handshakes SHALL give one byte per cycle.
REQ-025 ERR SHALL emit one byte (error code) via the same handshake, then return to IDLE.
REQ-026 rx_valid with "S" in START, WAIT, SEND or ERR SHALL abort: ch_start low, tx_valid low next cycle, FSM to IDLE, no further bytes.
REQ-027 Other rx bytes while busy SHALL be discarded and pulse drop.
REQ-028 ch_valid[i] and timeout expiry in the same cycle: ch_valid wins.
REQ-029 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and SHALL saturate, never wrap.

Reset
REQ-030 rst high SHALL immediately force IDLE, tx_valid=0, tx_data=0x00, ch_start=0, busy=0, drop=0, counters and buffers zero.
REQ-031 rst asserted mid-SEND SHALL drop the remaining bytes; no byte SHALL be emitted after reset release without a new command.

Configuration
REQ-032 Macro SENSOR_CMD_ROUTER_CHECKSUM_EN defined: SEND SHALL append one byte = 8-bit modulo-256 sum of header and payload bytes.
REQ-033 Macro undefined: no checksum byte, no checksum logic; frame = 1 + CH_BYTES bytes.

Structure
REQ-034 Package sensor_cmd_pkg SHALL hold the FSM state enum, CMD_ABORT ("S"), CMD_CH_BASE ("0"), ERR_BAD_CMD (0xFF), ERR_TIMEOUT (0xFE).
REQ-035 Sub-module sensor_tx_serializer SHALL hold the shift buffer, byte counter, optional checksum and the tx valid/ready handshake.

Verification
REQ-036 NUM_CH=2, CH_BYTES=5: rx "1", ch_valid[1] with 0x0504030201 -> ch_start=2'b10 one cycle, tx "1",01,02,03,04,05.
REQ-037 rx "Q" -> single tx 0xFF, busy returns 0, ch_start never asserted.
REQ-038 TIMEOUT_CYCLES=100: rx "0", no ch_valid -> tx 0xFE exactly after 100 WAIT cycles.
REQ-039 tx_ready low for 10 cycles mid-frame -> tx_data held stable, no byte lost or repeated; rx "D" while busy -> drop pulse.
REQ-040 rx "S" after second payload byte -> tx_valid low next cycle, IDLE; new "0" served normally.
REQ-041 With CHECKSUM_EN, rx "0", payload 0x0000000010 -> frame "0",10,00,00,00,00,0x40.
